// File: rtl/vga_sync_controller.sv
// VGA scan sequencer: pixel-rate clock-enable strobe, horizontal/vertical counters,
// and registered sync, blanking and frame/line strobes aligned with the coordinates.
module vga_sync_controller #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       enable,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || DIV < 1 || DIV > 16) begin : g_param_check
    $error("vga_sync_controller: illegal timing parameters");
  end

  localparam logic [3:0]  DIV_LAST     = 4'(DIV - 1);
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS        = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS        = 11'(V_ACTIVE);
  localparam logic [9:0]  H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        SYNC_ON      = 1'(SYNC_POL);
  localparam logic        SYNC_OFF     = ~SYNC_ON;

  function automatic logic sync_level(input logic [9:0] pos, input logic [9:0] first,
                                      input logic [9:0] last);
    return ((pos >= first) && (pos <= last)) ? SYNC_ON : SYNC_OFF;
  endfunction

  logic [3:0] prescale_r;
  logic       tick_r;
  logic [9:0] x_r;
  logic [9:0] y_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       video_on_r;
  logic       frame_start_r;
  logic       line_end_r;

  logic       adv_s;
  logic [9:0] next_x_s;
  logic [9:0] next_y_s;

  // Next scan position; outputs are decoded from it so they match the new coordinates.
  always_comb begin
    adv_s    = enable && (prescale_r == DIV_LAST);
    next_x_s = x_r;
    next_y_s = y_r;
    if (x_r == H_LAST) begin
      next_x_s = 10'd0;
      if (y_r == V_LAST) begin
        next_y_s = 10'd0;
      end else begin
        next_y_s = y_r + 10'd1;
      end
    end else begin
      next_x_s = x_r + 10'd1;
      next_y_s = y_r;
    end
  end

  // Prescaler, counters and all registered outputs advance together on the pixel strobe.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      prescale_r    <= 4'd0;
      tick_r        <= 1'b0;
      x_r           <= H_LAST;
      y_r           <= V_LAST;
      hsync_r       <= SYNC_OFF;
      vsync_r       <= SYNC_OFF;
      video_on_r    <= 1'b0;
      frame_start_r <= 1'b0;
      line_end_r    <= 1'b0;
    end else if (enable) begin
      tick_r <= adv_s;
      if (adv_s) begin
        prescale_r    <= 4'd0;
        x_r           <= next_x_s;
        y_r           <= next_y_s;
        hsync_r       <= sync_level(next_x_s, H_SYNC_FIRST, H_SYNC_LAST);
        vsync_r       <= sync_level(next_y_s, V_SYNC_FIRST, V_SYNC_LAST);
        video_on_r    <= ({1'b0, next_x_s} < H_VIS) && ({1'b0, next_y_s} < V_VIS);
        frame_start_r <= (next_x_s == 10'd0) && (next_y_s == 10'd0);
        line_end_r    <= (next_x_s == H_LAST);
      end else begin
        prescale_r    <= prescale_r + 4'd1;
        frame_start_r <= 1'b0;
        line_end_r    <= 1'b0;
      end
    end else begin
      tick_r        <= 1'b0;
      frame_start_r <= 1'b0;
      line_end_r    <= 1'b0;
    end
  end

  assign pix_tick    = tick_r;
  assign pixel_x     = x_r;
  assign pixel_y     = y_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign video_on    = video_on_r;
  assign frame_start = frame_start_r;
  assign line_end    = line_end_r;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Bench for vga_sync_controller: default 640x480 instance plus a small-timing instance
// (active-high sync) that covers whole frames, both checked against a pixel-index model.
module tb_vga_sync_controller;

  logic clk_100MHz = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk_100MHz = ~clk_100MHz;

  logic       b_tick, b_hs, b_vs, b_von, b_fs, b_le;
  logic [9:0] b_x, b_y;
  logic       s_tick, s_hs, s_vs, s_von, s_fs, s_le;
  logic [9:0] s_x, s_y;

  vga_sync_controller u_big (
    .clk_100MHz(clk_100MHz), .rst_n(rst_n), .enable(enable),
    .pix_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .frame_start(b_fs), .line_end(b_le)
  );

  vga_sync_controller #(
    .DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)
  ) u_small (
    .clk_100MHz(clk_100MHz), .rst_n(rst_n), .enable(enable),
    .pix_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_von), .frame_start(s_fs), .line_end(s_le)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: enabled edges since reset and whether the last edge was enabled.
  int n_r;
  bit en_last_r;

  always @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      n_r       <= 0;
      en_last_r <= 1'b0;
    end else begin
      en_last_r <= enable;
      if (enable) n_r <= n_r + 1;
    end
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Position = (pixels advanced - 1) mod frame size; reset sits at the last position.
  task automatic check_dut(input string tag, input int div, input int ha, input int hfp,
                           input int hsw, input int hbp, input int va, input int vfp,
                           input int vsw, input int vbp, input int pol,
                           input logic tick, input logic [9:0] x, input logic [9:0] y,
                           input logic hs, input logic vs, input logic von,
                           input logic fs, input logic le);
    int ht, vt, tot, lin, ex, ey, et;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    tot = ht * vt;
    lin = (n_r / div + tot - 1) % tot;
    ex  = lin % ht;
    ey  = lin / ht;
    et  = (en_last_r && n_r > 0 && (n_r % div) == 0) ? 1 : 0;
    cmp({tag, ".x"}, 32'(x), 32'(ex));
    cmp({tag, ".y"}, 32'(y), 32'(ey));
    cmp({tag, ".tick"}, 32'(tick), 32'(et));
    cmp({tag, ".hsync"}, 32'(hs),
        32'((ex >= ha + hfp && ex < ha + hfp + hsw) ? pol : 1 - pol));
    cmp({tag, ".vsync"}, 32'(vs),
        32'((ey >= va + vfp && ey < va + vfp + vsw) ? pol : 1 - pol));
    cmp({tag, ".video_on"}, 32'(von), 32'((n_r >= div && ex < ha && ey < va) ? 1 : 0));
    cmp({tag, ".frame_start"}, 32'(fs), 32'((et == 1 && ex == 0 && ey == 0) ? 1 : 0));
    cmp({tag, ".line_end"}, 32'(le), 32'((et == 1 && ex == ht - 1) ? 1 : 0));
  endtask

  task automatic check_all(input string tag);
    check_dut({tag, ".big"}, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0,
              b_tick, b_x, b_y, b_hs, b_vs, b_von, b_fs, b_le);
    check_dut({tag, ".small"}, 3, 20, 3, 5, 4, 10, 2, 2, 3, 1,
              s_tick, s_x, s_y, s_hs, s_vs, s_von, s_fs, s_le);
  endtask

  task automatic step(input string tag);
    @(posedge clk_100MHz);
    #1;
    check_all(tag);
  endtask

  int hs_low;
  int budget;
  int first_fs;
  int cyc;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk_100MHz);
    #1;
    check_all("reset");
    cmp("reset.x", 32'(b_x), 32'd799);
    cmp("reset.y", 32'(b_y), 32'd524);
    cmp("reset.hsync", 32'(b_hs), 32'd1);
    cmp("reset.small_hsync", 32'(s_hs), 32'd0);

    rst_n = 1'b1;
    repeat (3) begin
      step("prestart");
      cmp("prestart.tick", 32'(b_tick), 32'd0);
    end
    step("first");
    cmp("first.tick", 32'(b_tick), 32'd1);
    cmp("first.frame_start", 32'(b_fs), 32'd1);
    cmp("first.xy", 32'({b_x, b_y}), 32'd0);
    cmp("first.video_on", 32'(b_von), 32'd1);

    // One full line: count ticks with hsync low until x reaches the last column.
    hs_low = 0;
    budget = 0;
    while (!(b_tick && b_x == 10'd799) && budget < 4000) begin
      step("line");
      if (b_tick && !b_hs) hs_low++;
      budget++;
    end
    cmp("line.reached_end", 32'(budget < 4000), 32'd1);
    cmp("line.hsync_low_ticks", 32'(hs_low), 32'd96);
    cmp("line.line_end", 32'(b_le), 32'd1);
    repeat (4) step("wrap");
    cmp("wrap.x", 32'(b_x), 32'd0);
    cmp("wrap.y", 32'(b_y), 32'd1);

    // Freeze at x=300 with the prescaler at 2.
    budget = 0;
    while (!(b_tick && b_x == 10'd300) && budget < 2000) begin
      step("seek300");
      budget++;
    end
    cmp("seek300.found", 32'(budget < 2000), 32'd1);
    repeat (2) step("pre_freeze");
    enable = 1'b0;
    repeat (37) begin
      step("freeze");
      cmp("freeze.x", 32'(b_x), 32'd300);
      cmp("freeze.tick", 32'(b_tick), 32'd0);
    end
    enable = 1'b1;
    step("resume1");
    cmp("resume1.x", 32'(b_x), 32'd300);
    step("resume2");
    cmp("resume2.x", 32'(b_x), 32'd301);
    cmp("resume2.tick", 32'(b_tick), 32'd1);

    // Random enable pattern.
    repeat (5000) begin
      enable = ($urandom_range(0, 3) != 0);
      step("random");
    end
    enable = 1'b1;

    // Small instance: frame_start spacing in clk cycles.
    budget   = 0;
    first_fs = -1;
    cyc      = 0;
    while (budget < 5000 && cyc == 0) begin
      step("frame");
      if (s_fs) begin
        if (first_fs < 0) first_fs = budget;
        else cyc = budget - first_fs;
      end
      budget++;
    end
    cmp("frame.period", 32'(cyc), 32'd1632);

    // Asynchronous reset away from the clock edge at x=700.
    budget = 0;
    while (!(b_tick && b_x == 10'd700) && budget < 4000) begin
      step("seek700");
      budget++;
    end
    cmp("seek700.found", 32'(budget < 4000), 32'd1);
    @(negedge clk_100MHz);
    rst_n = 1'b0;
    #1;
    check_all("midreset");
    cmp("midreset.x", 32'(b_x), 32'd799);
    cmp("midreset.vsync", 32'(b_vs), 32'd1);
    repeat (2) step("midreset_hold");
    rst_n = 1'b1;
    repeat (4) step("restart");
    cmp("restart.frame_start", 32'(b_fs), 32'd1);
    cmp("restart.xy", 32'({b_x, b_y}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_controller.md
Name: vga_sync_controller

Overview:
- Sequences the VGA scan for the monitor path: derives a pixel-rate strobe from clk_100MHz (100 MHz / DIV = 25 MHz for 640x480@60) and runs the horizontal and vertical timing counters from it.
- Emits registered hsync, vsync and video_on, plus pixel coordinates and frame/line strobes for the downstream pixel generator.
- Sits between the board clock and the colour/pixel logic; it replaces ad-hoc clock division with a clock-enable strobe, so no derived clock is ever generated.

Parameters:
- DIV, 4, clk_100MHz cycles per pixel; legal range 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- SYNC_POL, 0, sync asserted level; 0 means active-low.

Ports:
- clk_100MHz  in  1  system clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan runs while high and freezes while low.
- pix_tick  out  1  one-cycle strobe marking the first clk cycle of each new pixel.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync at SYNC_POL level when asserted.
- vsync  out  1  vertical sync at SYNC_POL level when asserted.
- video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
- frame_start  out  1  one-cycle pulse when the counters become (0,0).
- line_end  out  1  one-cycle pulse when pixel_x becomes H_TOTAL-1.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800 and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525. Both totals must be at most 1024; elaboration fails otherwise.
- Reset (asynchronous, rst_n=0):
  - prescaler = 0, pix_tick = 0.
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1.
  - video_on = 0, frame_start = 0, line_end = 0.
  - hsync and vsync at their deasserted level (~SYNC_POL).
  - These values are mutually consistent: the position is in blanking and outside both sync windows.
- Prescaler, on each clk edge with enable=1:
  - if prescaler == DIV-1: prescaler <= 0, pix_tick <= 1, and the scan advances one pixel;
  - otherwise: prescaler <= prescaler+1, pix_tick <= 0.
  - With DIV=1, pix_tick stays high and the scan advances every cycle.
- Scan advance:
  - if pixel_x == H_TOTAL-1: pixel_x <= 0, and pixel_y <= (pixel_y == V_TOTAL-1) ? 0 : pixel_y+1;
  - otherwise pixel_x <= pixel_x+1.
- Output alignment:
  - hsync, vsync, video_on, frame_start and line_end are registered on the same edge as the counters.
  - They are decoded from the next counter values, so every output always describes the pixel_x/pixel_y present in the same cycle. There is zero skew between coordinates and sync.
- Window decodes (x = pixel_x, y = pixel_y):
  - hsync asserted for H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1, i.e. x = 656..751.
  - vsync asserted for V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1, i.e. y = 490..491.
  - vsync depends on y only; it does not realign to hsync.
- Strobes:
  - frame_start = 1 only in the pix_tick cycle in which the counters become (0,0); 0 in all other cycles.
  - line_end = 1 only in the pix_tick cycle in which x becomes H_TOTAL-1.
- enable = 0:
  - prescaler, counters and all level outputs hold their values.
  - pix_tick, frame_start and line_end are forced to 0.
  - When enable returns to 1, counting resumes from the held prescaler value; no pixel is skipped or repeated.
- rst_n asserted mid-frame: immediate return to the reset values. The first tick after release yields (0,0) with frame_start.
- Timing after reset release with enable=1: the first scan advance occurs on the DIV-th rising edge, since the prescaler steps 0→1→2→3 and then wraps.

Test Plan:
- Reset: hold rst_n=0 → pixel_x=799, pixel_y=524, hsync=vsync=1, video_on=0, pix_tick=frame_start=line_end=0.
- First pixel: release rst_n with enable=1, DIV=4 → on the 4th edge pix_tick=1, frame_start=1, pixel_x=0, pixel_y=0, video_on=1; thereafter pix_tick has a period of 4 cycles and a width of 1 cycle.
- Horizontal line: run one line → video_on falls at x=640; hsync is low for x=656..751 (96 ticks); line_end at x=799; the next tick gives x=0, y=1.
- Full frame: run 800×525 ticks → vsync low exactly for y=490..491; video_on never high for y ≥ 480; the next frame_start occurs exactly 420000 ticks (1,680,000 clk cycles) after the first.
- Enable freeze: drop enable for 37 cycles mid-line at x=300, prescaler=2 → outputs held, pix_tick=0; after re-enable, x=301 arrives 2 cycles later.
- Mid-operation reset: pulse rst_n low at x=700, y=100 → outputs return to the reset values asynchronously; after release the first tick gives (0,0) with frame_start=1.
